if_id_fetch_queue: RTL and testbench

- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry FIFO of fetched {pc, pc_4, instr} bundles between the IF and ID stages.
- Uses valid/ready handshakes on both sides, so the fetch stage can run ahead while decode stalls. The queue absorbs memory busywait bubbles instead of freezing the whole front end.
- A flush (branch/jump taken, hazard reset) discards every queued entry in one cycle.

---
 rtl/if_id_fetch_queue.sv | 120 ++++++++++++
 tb/tb_if_id_fetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_fetch_queue
// Purpose  : DEPTH-entry FIFO of fetched {pc, pc_4, instr} bundles between
//            the IF and ID stages. Valid/ready handshakes on both sides let
//            fetch run ahead while decode stalls. A flush empties the queue
//            in one cycle.
// Ports    : clk       - clock, rising edge
//            reset_n   - asynchronous active-low reset
//            flush     - synchronous clear of all entries
//            in_valid  - IF presents a bundle
//            in_pc     - PC of fetched instruction
//            in_pc_4   - PC + 4
//            in_instr  - fetched instruction
//            in_ready  - queue can accept (!full)
//            out_valid - head entry valid (!empty)
//            out_ready - ID consumes the head this cycle
//            out_pc    - head PC (0 when empty)
//            out_pc_4  - head PC + 4 (0 when empty)
//            out_instr - head instruction (0 bubble when empty)
//            count     - occupancy 0..DEPTH
//            full      - count == DEPTH
//            empty     - count == 0
// Revision : 1.0 - initial release
// ============================================================================
module if_id_fetch_queue #(
  parameter  int ADDR_W  = 32,
  parameter  int INSTR_W = 32,
  parameter  int DEPTH   = 4,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [ADDR_W-1:0]  in_pc_4,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_4,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int               c_PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  // Storage is intentionally not reset; entries are only observable when
  // count says they are valid.
  logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
  logic [ADDR_W-1:0]  r_pc_4_mem  [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Status comes purely from the registered count, so in_ready never
  // depends combinationally on out_ready.
  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = out_ready & ~w_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      // Flush wins over any handshake in the same cycle.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A write discarded by flush is harmless: the slot is outside the valid
  // window once the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= in_pc;
      r_pc_4_mem[r_wr_ptr]  <= in_pc_4;
      r_instr_mem[r_wr_ptr] <= in_instr;
    end
  end

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_pc    = w_empty ? '0 : r_pc_mem[r_rd_ptr];
  assign out_pc_4  = w_empty ? '0 : r_pc_4_mem[r_rd_ptr];
  assign out_instr = w_empty ? '0 : r_instr_mem[r_rd_ptr];
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_if_id_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_fetch_queue
// Purpose  : Directed self-checking bench for if_id_fetch_queue (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_fetch_queue;

  localparam int c_ADDR_W  = 32;
  localparam int c_INSTR_W = 32;
  localparam int c_DEPTH   = 4;
  localparam int c_CNT_W   = $clog2(c_DEPTH) + 1;

  logic                 clk;
  logic                 reset_n;
  logic                 flush;
  logic                 in_valid;
  logic [c_ADDR_W-1:0]  in_pc;
  logic [c_ADDR_W-1:0]  in_pc_4;
  logic [c_INSTR_W-1:0] in_instr;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [c_ADDR_W-1:0]  out_pc;
  logic [c_ADDR_W-1:0]  out_pc_4;
  logic [c_INSTR_W-1:0] out_instr;
  logic [c_CNT_W-1:0]   count;
  logic                 full;
  logic                 empty;

  int n_tests;
  int n_fail;

  if_id_fetch_queue #(
    .ADDR_W  (c_ADDR_W),
    .INSTR_W (c_INSTR_W),
    .DEPTH   (c_DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_pc_4   (in_pc_4),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_pc_4  (out_pc_4),
    .out_instr (out_instr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a bundle whose fields are all derived from its pc.
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_pc_4   = pc + 32'd4;
    in_instr  = 32'hA000_0000 | pc;
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".pc"},    64'(out_pc),    64'(pc));
    chk({tag, ".pc_4"},  64'(out_pc_4),  64'(pc + 32'd4));
    chk({tag, ".instr"}, 64'(out_instr), 64'(32'hA000_0000 | pc));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".count"},    64'(count),     64'd0);
    chk({tag, ".empty"},    64'(empty),     64'd1);
    chk({tag, ".full"},     64'(full),      64'd0);
    chk({tag, ".in_ready"}, 64'(in_ready),  64'd1);
    chk({tag, ".valid"},    64'(out_valid), 64'd0);
    chk({tag, ".pc"},       64'(out_pc),    64'd0);
    chk({tag, ".pc_4"},     64'(out_pc_4),  64'd0);
    chk({tag, ".instr"},    64'(out_instr), 64'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    flush   = 1'b0;
    drive(1'b0, 32'h0, 1'b0);

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk_empty("reset");
    reset_n = 1'b1;
    step();
    chk_empty("post_reset");

    // ---------------- fill ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0);
      step();
      chk($sformatf("fill%0d.count", i), 64'(count), 64'(i + 1));
      chk_head($sformatf("fill%0d.head", i), 32'h0);
    end
    chk("fill.full",     64'(full),     64'd1);
    chk("fill.in_ready", 64'(in_ready), 64'd0);
    chk("fill.empty",    64'(empty),    64'd0);

    // 5th push is refused
    drive(1'b1, 32'h10, 1'b0);
    step();
    chk("refuse.count", 64'(count), 64'd4);
    chk_head("refuse.head", 32'h0);

    // ---------------- drain ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      chk_head($sformatf("drain%0d", i), 32'(4 * i));
      step();
      chk($sformatf("drain%0d.count", i), 64'(count), 64'(3 - i));
    end
    chk_empty("drained");

    // ---------------- simultaneous push/pop at count=2 ----------------
    drive(1'b1, 32'h40, 1'b0); step();
    drive(1'b1, 32'h44, 1'b0); step();
    chk("pp.pre_count", 64'(count), 64'd2);
    chk_head("pp.pre", 32'h40);
    drive(1'b1, 32'h20, 1'b1); step();
    chk("pp.count", 64'(count), 64'd2);
    chk_head("pp.head1", 32'h44);
    drive(1'b0, 32'h0, 1'b1); step();
    chk("pp.count1", 64'(count), 64'd1);
    chk_head("pp.head2", 32'h20);
    step();
    chk_empty("pp.done");

    // ---------------- full + pop + push attempt ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h50 + 32'(4 * i), 1'b0);
      step();
    end
    chk("fpp.pre_count", 64'(count), 64'd4);
    drive(1'b1, 32'h60, 1'b1);
    chk("fpp.pre_ready", 64'(in_ready), 64'd0);
    step();
    chk("fpp.count",    64'(count),    64'd3);
    chk("fpp.in_ready", 64'(in_ready), 64'd1);
    chk("fpp.full",     64'(full),     64'd0);
    chk_head("fpp.head", 32'h54);

    // ---------------- flush with push and pop requested ----------------
    drive(1'b1, 32'h70, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_empty("flush");
    // pointers must restart at 0 as well
    drive(1'b1, 32'h80, 1'b0); step();
    chk("flush.next_count", 64'(count), 64'd1);
    chk_head("flush.next", 32'h80);
    drive(1'b0, 32'h0, 1'b1); step();
    chk_empty("flush.drained");

    // ---------------- wrap-around streaming ----------------
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b1);
      step();
      chk($sformatf("wrap%0d.count", i), 64'(count), 64'd1);
      chk_head($sformatf("wrap%0d", i), 32'h100 + 32'(4 * i));
    end
    drive(1'b0, 32'h0, 1'b1); step();
    chk_empty("wrap.done");

    // ---------------- asynchronous reset mid-operation ----------------
    drive(1'b1, 32'h200, 1'b0); step();
    drive(1'b1, 32'h204, 1'b0); step();
    chk("areset.pre_count", 64'(count), 64'd2);
    flush   = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk_empty("areset");
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    chk_empty("areset.release");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
